// File: rtl/dmux_stream.sv
// Pipelined MUX_SIZE-ary demux tree: one valid-qualified beat in, steered to one output
// or broadcast to all, STAGES register levels deep, with out-of-range select drop counting.
module dmux_stream #(
    parameter int WIDTH        = 8,
    parameter int OUTPUT_COUNT = 5,
    parameter int MUX_SIZE     = 2,
    parameter int ZERO_IDLE    = 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              ce,
    input  logic                              in_valid,
    input  logic [$clog2(OUTPUT_COUNT)-1:0]   in_sel,
    input  logic                              in_bcast,
    input  logic [WIDTH-1:0]                  in_data,
    output logic [OUTPUT_COUNT-1:0]           out_valid,
    output logic [WIDTH*OUTPUT_COUNT-1:0]     out_data,
    output logic                              err_sel,
    output logic [15:0]                       drop_count
);

    function automatic int calc_stages();
        int s;
        int cap;
        s   = 1;
        cap = MUX_SIZE;
        for (int i = 0; i < 32; i++) begin
            if (cap < OUTPUT_COUNT) begin
                cap = cap * MUX_SIZE;
                s   = s + 1;
            end
        end
        return s;
    endfunction

    localparam int SEL_WIDTH  = $clog2(MUX_SIZE);
    localparam int STAGES     = calc_stages();
    localparam int PADDED_SEL = STAGES * SEL_WIDTH;
    localparam int NODES      = MUX_SIZE ** STAGES;

    // A node exists only if the first output index under its subtree is a real output.
    function automatic bit node_built(int k, int j);
        return (j * (MUX_SIZE ** (STAGES - 1 - k))) < OUTPUT_COUNT;
    endfunction

    logic                  valid_q [STAGES][NODES];
    logic                  valid_d [STAGES][NODES];
    logic [WIDTH-1:0]      data_q  [STAGES][NODES];
    logic [WIDTH-1:0]      data_d  [STAGES][NODES];
    logic [PADDED_SEL-1:0] sel_q   [STAGES][NODES];
    logic [PADDED_SEL-1:0] sel_d   [STAGES][NODES];
    logic                  bcast_q [STAGES][NODES];
    logic                  bcast_d [STAGES][NODES];

    logic        err_q;
    logic [15:0] drop_q;

    logic                  legal;
    logic                  drop;
    logic [PADDED_SEL-1:0] sel_pad;

    always_comb begin
        logic                  p_valid;
        logic [SEL_WIDTH-1:0]  p_digit;
        logic [WIDTH-1:0]      p_data;
        logic [PADDED_SEL-1:0] p_sel;
        logic                  p_bcast;
        logic                  hit;
        int                    pk;
        int                    pj;

        legal   = in_bcast | (32'(in_sel) < OUTPUT_COUNT);
        drop    = in_valid & ce & ~legal;
        sel_pad = PADDED_SEL'(in_sel);

        for (int k = 0; k < STAGES; k++) begin
            for (int j = 0; j < NODES; j++) begin
                pk = (k == 0) ? 0 : k - 1;
                pj = j / MUX_SIZE;
                if (k == 0) begin
                    p_valid = in_valid & legal;
                    p_data  = in_data;
                    p_sel   = sel_pad;
                    p_bcast = in_bcast;
                end else begin
                    p_valid = valid_q[pk][pj];
                    p_data  = data_q[pk][pj];
                    p_sel   = sel_q[pk][pj];
                    p_bcast = bcast_q[pk][pj];
                end
                // Each level consumes the top digit and shifts the rest up for the next.
                p_digit = p_sel[PADDED_SEL-1 -: SEL_WIDTH];
                hit     = p_valid & ((p_digit == SEL_WIDTH'(j % MUX_SIZE)) | p_bcast);

                valid_d[k][j] = hit;
                data_d[k][j]  = hit ? p_data : ((ZERO_IDLE != 0) ? '0 : data_q[k][j]);
                sel_d[k][j]   = p_sel << SEL_WIDTH;
                bcast_d[k][j] = p_bcast;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q  <= 1'b0;
            drop_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                for (int j = 0; j < NODES; j++) begin
                    valid_q[k][j] <= 1'b0;
                    data_q[k][j]  <= '0;
                    sel_q[k][j]   <= '0;
                    bcast_q[k][j] <= 1'b0;
                end
            end
        end else begin
            err_q <= drop;
            if (drop && (drop_q != 16'hFFFF)) begin
                drop_q <= drop_q + 16'd1;
            end
            if (ce) begin
                for (int k = 0; k < STAGES; k++) begin
                    for (int j = 0; j < NODES; j++) begin
                        if (node_built(k, j)) begin
                            valid_q[k][j] <= valid_d[k][j];
                            data_q[k][j]  <= data_d[k][j];
                            sel_q[k][j]   <= sel_d[k][j];
                            bcast_q[k][j] <= bcast_d[k][j];
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        out_valid = '0;
        out_data  = '0;
        for (int i = 0; i < OUTPUT_COUNT; i++) begin
            out_valid[i]                = valid_q[STAGES-1][i];
            out_data[i*WIDTH +: WIDTH]  = data_q[STAGES-1][i];
        end
    end

    assign err_sel    = err_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_dmux_stream.sv
// Directed bench for dmux_stream: a 5-output binary tree and a 16-output radix-4 tree
// with idle-data hold, sharing one clock and reset.
module tb_dmux_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         ce, in_valid, in_bcast;
    logic [2:0]   in_sel;
    logic [7:0]   in_data;
    logic [4:0]   out_valid;
    logic [39:0]  out_data;
    logic         err_sel;
    logic [15:0]  drop_count;

    logic         ce2, in_valid2, in_bcast2;
    logic [3:0]   in_sel2;
    logic [7:0]   in_data2;
    logic [15:0]  out_valid2;
    logic [127:0] out_data2;
    logic         err_sel2;
    logic [15:0]  drop_count2;

    int pass_cnt = 0;
    int total    = 0;

    dmux_stream #(.WIDTH(8), .OUTPUT_COUNT(5), .MUX_SIZE(2), .ZERO_IDLE(1)) dut (
        .clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(in_valid), .in_sel(in_sel),
        .in_bcast(in_bcast), .in_data(in_data), .out_valid(out_valid),
        .out_data(out_data), .err_sel(err_sel), .drop_count(drop_count)
    );

    dmux_stream #(.WIDTH(8), .OUTPUT_COUNT(16), .MUX_SIZE(4), .ZERO_IDLE(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .ce(ce2), .in_valid(in_valid2), .in_sel(in_sel2),
        .in_bcast(in_bcast2), .in_data(in_data2), .out_valid(out_valid2),
        .out_data(out_data2), .err_sel(err_sel2), .drop_count(drop_count2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ce = 1'b1; in_valid = 1'b0; in_bcast = 1'b0; in_sel = '0; in_data = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        ce2 = 1'b1; in_valid2 = 1'b0; in_bcast2 = 1'b0; in_sel2 = '0; in_data2 = '0;
        step(); step();
        total++; if (out_valid !== 5'b0) $display("FAIL reset_valid got %b want 0", out_valid); else pass_cnt++;
        total++; if (out_data !== 40'h0) $display("FAIL reset_data got %h want 0", out_data); else pass_cnt++;
        total++; if (err_sel !== 1'b0) $display("FAIL reset_err got %b want 0", err_sel); else pass_cnt++;
        total++; if (drop_count !== 16'h0) $display("FAIL reset_drop got %h want 0", drop_count); else pass_cnt++;
        total++; if (out_valid2 !== 16'h0) $display("FAIL reset_valid2 got %h want 0", out_valid2); else pass_cnt++;
        total++; if (out_data2 !== 128'h0) $display("FAIL reset_data2 got %h want 0", out_data2); else pass_cnt++;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        in_valid = 1'b1; in_sel = 3'd3; in_data = 8'hA5;
        step();
        idle_inputs();
        total++; if (out_valid !== 5'b0) $display("FAIL single_c1_valid got %b want 0", out_valid); else pass_cnt++;
        total++; if (err_sel !== 1'b0) $display("FAIL single_err got %b want 0", err_sel); else pass_cnt++;
        step();
        total++; if (out_valid !== 5'b0) $display("FAIL single_c2_valid got %b want 0", out_valid); else pass_cnt++;
        step();
        total++; if (out_valid !== 5'b01000) $display("FAIL single_valid got %b want 01000", out_valid); else pass_cnt++;
        total++; if (out_data !== 40'h00A5000000) $display("FAIL single_data got %h want 00a5000000", out_data); else pass_cnt++;
        step();
        total++; if (out_valid !== 5'b0) $display("FAIL single_after_valid got %b want 0", out_valid); else pass_cnt++;
        total++; if (out_data !== 40'h0) $display("FAIL single_zero_idle got %h want 0", out_data); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [4:0]  exp_v;
        logic [39:0] exp_d;
        for (int c = 0; c < 9; c++) begin
            if (c < 5) begin
                in_valid = 1'b1; in_sel = 3'(c); in_data = 8'h10 + 8'(c);
            end else begin
                idle_inputs();
            end
            exp_v = '0;
            exp_d = '0;
            if (c >= 3 && c <= 7) begin
                exp_v = 5'(1 << (c - 3));
                exp_d = 40'(8'h10 + 8'(c - 3)) << (8 * (c - 3));
            end
            total++; if (out_valid !== exp_v) $display("FAIL b2b_valid c%0d got %b want %b", c, out_valid, exp_v); else pass_cnt++;
            total++; if (out_data !== exp_d) $display("FAIL b2b_data c%0d got %h want %h", c, out_data, exp_d); else pass_cnt++;
            step();
        end
    endtask

    task automatic test_bad_sel();
        in_valid = 1'b1; in_sel = 3'd6; in_data = 8'hEE;
        step();
        idle_inputs();
        total++; if (err_sel !== 1'b1) $display("FAIL bad6_err got %b want 1", err_sel); else pass_cnt++;
        total++; if (drop_count !== 16'd1) $display("FAIL bad6_drop got %0d want 1", drop_count); else pass_cnt++;
        step();
        total++; if (err_sel !== 1'b0) $display("FAIL bad6_err_pulse got %b want 0", err_sel); else pass_cnt++;
        for (int c = 2; c < 6; c++) begin
            total++; if (out_valid !== 5'b0) $display("FAIL bad6_no_out c%0d got %b want 0", c, out_valid); else pass_cnt++;
            step();
        end
        in_valid = 1'b1; in_sel = 3'd5; in_data = 8'hDD;
        step();
        idle_inputs();
        total++; if (err_sel !== 1'b1) $display("FAIL bad5_err got %b want 1", err_sel); else pass_cnt++;
        total++; if (drop_count !== 16'd2) $display("FAIL bad5_drop got %0d want 2", drop_count); else pass_cnt++;
        for (int c = 1; c < 5; c++) begin
            total++; if (out_valid !== 5'b0) $display("FAIL bad5_no_out c%0d got %b want 0", c, out_valid); else pass_cnt++;
            step();
        end
    endtask

    task automatic test_saturate();
        in_valid = 1'b1; in_sel = 3'd7; in_data = 8'h00;
        repeat (65533) step();
        total++; if (drop_count !== 16'hFFFF) $display("FAIL sat_reach got %h want ffff", drop_count); else pass_cnt++;
        total++; if (err_sel !== 1'b1) $display("FAIL sat_err got %b want 1", err_sel); else pass_cnt++;
        repeat (3) step();
        total++; if (drop_count !== 16'hFFFF) $display("FAIL sat_hold got %h want ffff", drop_count); else pass_cnt++;
        total++; if (err_sel !== 1'b1) $display("FAIL sat_err_hold got %b want 1", err_sel); else pass_cnt++;
        idle_inputs();
        step();
        total++; if (err_sel !== 1'b0) $display("FAIL sat_err_clear got %b want 0", err_sel); else pass_cnt++;
        total++; if (drop_count !== 16'hFFFF) $display("FAIL sat_final got %h want ffff", drop_count); else pass_cnt++;
    endtask

    task automatic test_bcast();
        in_valid = 1'b1; in_bcast = 1'b1; in_sel = 3'd7; in_data = 8'h3C;
        step();
        idle_inputs();
        total++; if (err_sel !== 1'b0) $display("FAIL bcast_err got %b want 0", err_sel); else pass_cnt++;
        total++; if (drop_count !== 16'hFFFF) $display("FAIL bcast_drop got %h want ffff", drop_count); else pass_cnt++;
        step(); step();
        total++; if (out_valid !== 5'b11111) $display("FAIL bcast_valid got %b want 11111", out_valid); else pass_cnt++;
        total++; if (out_data !== 40'h3C3C3C3C3C) $display("FAIL bcast_data got %h want 3c3c3c3c3c", out_data); else pass_cnt++;
        step();
        total++; if (out_valid !== 5'b0) $display("FAIL bcast_after got %b want 0", out_valid); else pass_cnt++;
    endtask

    task automatic test_stall_reset();
        in_valid = 1'b1; in_sel = 3'd2; in_data = 8'h77;
        step();
        ce = 1'b0; in_valid = 1'b1; in_sel = 3'd6;
        step();
        total++; if (err_sel !== 1'b0) $display("FAIL stall_no_err got %b want 0", err_sel); else pass_cnt++;
        in_valid = 1'b0; in_sel = 3'd0;
        step();
        ce = 1'b1;
        total++; if (out_valid !== 5'b0) $display("FAIL stall_c3 got %b want 0", out_valid); else pass_cnt++;
        step();
        total++; if (out_valid !== 5'b0) $display("FAIL stall_c4 got %b want 0", out_valid); else pass_cnt++;
        step();
        total++; if (out_valid !== 5'b00100) $display("FAIL stall_c5_valid got %b want 00100", out_valid); else pass_cnt++;
        total++; if (out_data !== 40'h0000770000) $display("FAIL stall_c5_data got %h want 0000770000", out_data); else pass_cnt++;
        total++; if (drop_count !== 16'hFFFF) $display("FAIL stall_drop got %h want ffff", drop_count); else pass_cnt++;
        ce = 1'b0;
        step();
        total++; if (out_valid !== 5'b00100) $display("FAIL stall_hold got %b want 00100", out_valid); else pass_cnt++;
        rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 5'b0) $display("FAIL async_rst_valid got %b want 0", out_valid); else pass_cnt++;
        total++; if (out_data !== 40'h0) $display("FAIL async_rst_data got %h want 0", out_data); else pass_cnt++;
        total++; if (drop_count !== 16'h0) $display("FAIL async_rst_drop got %h want 0", drop_count); else pass_cnt++;
        step();
        rst_n = 1'b1;
        idle_inputs();
        step();
        // Second flight: reset lands while the beat is frozen mid-tree.
        in_valid = 1'b1; in_sel = 3'd2; in_data = 8'h88;
        step();
        idle_inputs();
        ce = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        ce = 1'b1;
        for (int c = 3; c < 8; c++) begin
            total++; if (out_valid !== 5'b0) $display("FAIL rst_flush c%0d got %b want 0", c, out_valid); else pass_cnt++;
            step();
        end
    endtask

    task automatic test_radix4_hold();
        in_valid2 = 1'b1; in_sel2 = 4'd3; in_data2 = 8'h33;
        step();
        total++; if (out_valid2 !== 16'h0) $display("FAIL r4_c1 got %h want 0", out_valid2); else pass_cnt++;
        in_sel2 = 4'd13; in_data2 = 8'h5A;
        step();
        in_valid2 = 1'b0; in_sel2 = '0; in_data2 = '0;
        total++; if (out_valid2 !== 16'h0008) $display("FAIL r4_c2_valid got %h want 0008", out_valid2); else pass_cnt++;
        total++; if (out_data2 !== (128'h33 << 24)) $display("FAIL r4_c2_data got %h want %h", out_data2, 128'h33 << 24); else pass_cnt++;
        step();
        total++; if (out_valid2 !== 16'h2000) $display("FAIL r4_c3_valid got %h want 2000", out_valid2); else pass_cnt++;
        total++; if (out_data2 !== ((128'h5A << 104) | (128'h33 << 24))) $display("FAIL r4_c3_data got %h want %h", out_data2, (128'h5A << 104) | (128'h33 << 24)); else pass_cnt++;
        step();
        total++; if (out_valid2 !== 16'h0) $display("FAIL r4_c4_valid got %h want 0", out_valid2); else pass_cnt++;
        total++; if (out_data2 !== ((128'h5A << 104) | (128'h33 << 24))) $display("FAIL r4_retain got %h want %h", out_data2, (128'h5A << 104) | (128'h33 << 24)); else pass_cnt++;
        total++; if (err_sel2 !== 1'b0 || drop_count2 !== 16'h0) $display("FAIL r4_err got %b/%h want 0/0", err_sel2, drop_count2); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_bad_sel();
        test_saturate();
        test_bcast();
        test_stall_reset();
        test_radix4_hold();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
